// File: rtl/sprite_compositor_pkg.sv
// Shared types and defaults for the sprite compositor.
package sprite_pkg;

  localparam int COORD_W_DEF = 10;

  typedef logic [23:0] rgb_t;

  localparam rgb_t KEY_RGB_DEF = 24'hFF00FF;

  typedef struct packed {
    logic [COORD_W_DEF-1:0] x;
    logic [COORD_W_DEF-1:0] y;
    logic                   vis;
  } pos_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sprite_compositor_hit_unit.sv
// Per-sprite bound compare and local ROM address, registered (stage 0).
module sprite_hit_unit
  import sprite_pkg::*;
#(
  parameter int  COORD_W = COORD_W_DEF,
  parameter int  SPR_W   = 32,
  parameter int  SPR_H   = 32,
  localparam int XW      = $clog2(SPR_W),
  localparam int YW      = $clog2(SPR_H)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COORD_W-1:0] vga_x,
  input  logic [COORD_W-1:0] vga_y,
  input  logic [COORD_W-1:0] pos_x,
  input  logic [COORD_W-1:0] pos_y,
  input  logic               pos_vis,
  output logic               hit,
  output logic [XW-1:0]      lx,
  output logic [YW-1:0]      ly
);

  localparam int EW = COORD_W + 1;

  logic [EW-1:0]      x_end;
  logic [EW-1:0]      y_end;
  logic [COORD_W-1:0] dx;
  logic [COORD_W-1:0] dy;
  logic               in_x;
  logic               in_y;

  logic          hit_d, hit_q;
  logic [XW-1:0] lx_d, lx_q;
  logic [YW-1:0] ly_d, ly_q;

  // Right/bottom edges use one extra bit so a sprite near max coord never wraps.
  always_comb begin
    x_end = {1'b0, pos_x} + EW'(SPR_W);
    y_end = {1'b0, pos_y} + EW'(SPR_H);
    in_x  = (vga_x >= pos_x) && ({1'b0, vga_x} < x_end);
    in_y  = (vga_y >= pos_y) && ({1'b0, vga_y} < y_end);
    dx    = vga_x - pos_x;
    dy    = vga_y - pos_y;
    hit_d = pos_vis & in_x & in_y;
    lx_d  = dx[XW-1:0];
    ly_d  = dy[YW-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_q <= 1'b0;
      lx_q  <= '0;
      ly_q  <= '0;
    end else begin
      hit_q <= hit_d;
      lx_q  <= lx_d;
      ly_q  <= ly_d;
    end
  end

  assign hit = hit_q;
  assign lx  = lx_q;
  assign ly  = ly_q;

endmodule

// File: rtl/sprite_compositor.sv
// Multi-sprite compositor: fixed priority, colour key, double-buffered positions.
// Define SPRITE_COLLISION_EN to build the per-frame collision accumulator.
module sprite_compositor
  import sprite_pkg::*;
#(
  parameter int   N_SPR   = 4,
  parameter int   SPR_W   = 32,
  parameter int   SPR_H   = 32,
  parameter int   COORD_W = COORD_W_DEF,
  parameter int   ROM_LAT = 1,
  parameter rgb_t KEY_RGB = KEY_RGB_DEF,
  localparam int  IW      = idx_w(N_SPR),
  localparam int  XW      = $clog2(SPR_W),
  localparam int  YW      = $clog2(SPR_H)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [COORD_W-1:0]    vga_x,
  input  logic [COORD_W-1:0]    vga_y,
  input  logic                  frame_start,
  input  logic                  pos_wr,
  input  logic [IW-1:0]         pos_idx,
  input  logic [COORD_W-1:0]    pos_x,
  input  logic [COORD_W-1:0]    pos_y,
  input  logic                  pos_vis,
  output logic [N_SPR*XW-1:0]   rom_x,
  output logic [N_SPR*YW-1:0]   rom_y,
  input  logic [N_SPR*24-1:0]   rom_rgb,
  output logic [7:0]            R,
  output logic [7:0]            G,
  output logic [7:0]            B,
  output logic                  enable,
  output logic [IW-1:0]         spr_id,
  output logic [N_SPR-1:0]      coll_flags,
  output logic                  coll_valid
);

  logic [COORD_W-1:0] pend_x_d [N_SPR];
  logic [COORD_W-1:0] pend_x_q [N_SPR];
  logic [COORD_W-1:0] pend_y_d [N_SPR];
  logic [COORD_W-1:0] pend_y_q [N_SPR];
  logic [N_SPR-1:0]   pend_v_d, pend_v_q;
  logic [COORD_W-1:0] act_x_d  [N_SPR];
  logic [COORD_W-1:0] act_x_q  [N_SPR];
  logic [COORD_W-1:0] act_y_d  [N_SPR];
  logic [COORD_W-1:0] act_y_q  [N_SPR];
  logic [N_SPR-1:0]   act_v_d, act_v_q;
  logic               idx_ok;

  if ((1 << IW) == N_SPR) begin : g_idx_full
    assign idx_ok = 1'b1;
  end else begin : g_idx_part
    assign idx_ok = int'(pos_idx) < N_SPR;
  end

  // Active set takes the pending set including a same-cycle write.
  always_comb begin
    pend_x_d = pend_x_q;
    pend_y_d = pend_y_q;
    pend_v_d = pend_v_q;
    if (pos_wr && idx_ok) begin
      pend_x_d[pos_idx] = pos_x;
      pend_y_d[pos_idx] = pos_y;
      pend_v_d[pos_idx] = pos_vis;
    end
    act_x_d = act_x_q;
    act_y_d = act_y_q;
    act_v_d = act_v_q;
    if (frame_start) begin
      act_x_d = pend_x_d;
      act_y_d = pend_y_d;
      act_v_d = pend_v_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_SPR; i++) begin
        pend_x_q[i] <= '0;
        pend_y_q[i] <= '0;
        act_x_q[i]  <= '0;
        act_y_q[i]  <= '0;
      end
      pend_v_q <= '0;
      act_v_q  <= '0;
    end else begin
      pend_x_q <= pend_x_d;
      pend_y_q <= pend_y_d;
      pend_v_q <= pend_v_d;
      act_x_q  <= act_x_d;
      act_y_q  <= act_y_d;
      act_v_q  <= act_v_d;
    end
  end

  logic [N_SPR-1:0] hit_s0;

  for (genvar i = 0; i < N_SPR; i++) begin : g_hit
    sprite_hit_unit #(
      .COORD_W (COORD_W),
      .SPR_W   (SPR_W),
      .SPR_H   (SPR_H)
    ) u_hit (
      .clk     (clk),
      .rst     (rst),
      .vga_x   (vga_x),
      .vga_y   (vga_y),
      .pos_x   (act_x_q[i]),
      .pos_y   (act_y_q[i]),
      .pos_vis (act_v_q[i]),
      .hit     (hit_s0[i]),
      .lx      (rom_x[i*XW +: XW]),
      .ly      (rom_y[i*YW +: YW])
    );
  end

  logic [N_SPR-1:0] hit_dl;

  if (ROM_LAT == 0) begin : g_nodly
    assign hit_dl = hit_s0;
  end else begin : g_dly
    logic [N_SPR-1:0] pipe_d [ROM_LAT];
    logic [N_SPR-1:0] pipe_q [ROM_LAT];

    always_comb begin
      pipe_d[0] = hit_s0;
      for (int k = 1; k < ROM_LAT; k++) begin
        pipe_d[k] = pipe_q[k-1];
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int k = 0; k < ROM_LAT; k++) begin
          pipe_q[k] <= '0;
        end
      end else begin
        pipe_q <= pipe_d;
      end
    end

    assign hit_dl = pipe_q[ROM_LAT-1];
  end

  logic [N_SPR-1:0] opaque;
  rgb_t             rgb_d, rgb_q;
  logic             en_d, en_q;
  logic [IW-1:0]    id_d, id_q;

  // Scan high to low so the lowest opaque index is the last to assign.
  always_comb begin
    opaque = '0;
    rgb_d  = '0;
    en_d   = 1'b0;
    id_d   = '0;
    for (int i = 0; i < N_SPR; i++) begin
      opaque[i] = hit_dl[i] && (rom_rgb[i*24 +: 24] != KEY_RGB);
    end
    for (int i = N_SPR - 1; i >= 0; i--) begin
      if (opaque[i]) begin
        rgb_d = rom_rgb[i*24 +: 24];
        en_d  = 1'b1;
        id_d  = IW'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_q <= '0;
      en_q  <= 1'b0;
      id_q  <= '0;
    end else begin
      rgb_q <= rgb_d;
      en_q  <= en_d;
      id_q  <= id_d;
    end
  end

  assign R      = rgb_q[23:16];
  assign G      = rgb_q[15:8];
  assign B      = rgb_q[7:0];
  assign enable = en_q;
  assign spr_id = id_q;

`ifdef SPRITE_COLLISION_EN
  logic [N_SPR-1:0] coll_now;
  logic [N_SPR-1:0] coll_acc_d, coll_acc_q;
  logic [N_SPR-1:0] coll_flags_d, coll_flags_q;
  logic             coll_valid_d, coll_valid_q;

  // Collisions seen on the frame_start cycle seed the next frame.
  always_comb begin
    coll_now     = ($countones(opaque) >= 2) ? opaque : '0;
    coll_acc_d   = coll_acc_q | coll_now;
    coll_flags_d = coll_flags_q;
    coll_valid_d = 1'b0;
    if (frame_start) begin
      coll_flags_d = coll_acc_q;
      coll_acc_d   = coll_now;
      coll_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      coll_acc_q   <= '0;
      coll_flags_q <= '0;
      coll_valid_q <= 1'b0;
    end else begin
      coll_acc_q   <= coll_acc_d;
      coll_flags_q <= coll_flags_d;
      coll_valid_q <= coll_valid_d;
    end
  end

  assign coll_flags = coll_flags_q;
  assign coll_valid = coll_valid_q;
`else
  assign coll_flags = '0;
  assign coll_valid = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_compositor.sv
// Scoreboard bench for sprite_compositor with a pixel-level reference model.
module tb_sprite_compositor;

  localparam int N   = 4;
  localparam int SW  = 32;
  localparam int SH  = 32;
  localparam int CW  = 10;
  localparam int LAT = 1;
  localparam logic [23:0] KEY = 24'hFF00FF;

  logic          clk = 1'b0;
  logic          rst;
  logic [CW-1:0] vga_x, vga_y, pos_x, pos_y;
  logic          frame_start, pos_wr, pos_vis;
  logic [1:0]    pos_idx;
  logic [N*5-1:0]  rom_x, rom_y;
  logic [N*24-1:0] rom_rgb;
  logic [7:0]    R, G, B;
  logic          enable;
  logic [1:0]    spr_id;
  logic [N-1:0]  coll_flags;
  logic          coll_valid;

  always #5 clk = ~clk;

  sprite_compositor #(
    .N_SPR(N), .SPR_W(SW), .SPR_H(SH), .COORD_W(CW), .ROM_LAT(LAT), .KEY_RGB(KEY)
  ) dut (
    .clk(clk), .rst(rst), .vga_x(vga_x), .vga_y(vga_y),
    .frame_start(frame_start), .pos_wr(pos_wr), .pos_idx(pos_idx),
    .pos_x(pos_x), .pos_y(pos_y), .pos_vis(pos_vis),
    .rom_x(rom_x), .rom_y(rom_y), .rom_rgb(rom_rgb),
    .R(R), .G(G), .B(B), .enable(enable), .spr_id(spr_id),
    .coll_flags(coll_flags), .coll_valid(coll_valid)
  );

  logic [N-1:0] key_all = '0;
  bit           pat_en  = 1'b0;

  function automatic logic [23:0] rom_fn(input int s, input int lx, input int ly);
    if (key_all[s]) return KEY;
    if (pat_en && ((lx * 3 + ly) % 11 == 5)) return KEY;
    return {8'(s * 40 + 1), 8'(lx * 7 + 3), 8'(ly * 5 + s)};
  endfunction

  // Sprite ROMs with one cycle of read latency.
  always @(posedge clk)
    for (int s = 0; s < N; s++)
      rom_rgb[s*24 +: 24] <= rom_fn(s, int'(rom_x[s*5 +: 5]), int'(rom_y[s*5 +: 5]));

  typedef struct { int due; bit en; int id; logic [23:0] rgb; } exp_t;
  typedef struct { int t; logic [N-1:0] b; } cl_t;

  exp_t q[$];
  cl_t  cq[$];
  exp_t me;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  int   m_px[N], m_py[N], a_px[N], a_py[N];
  bit   m_pv[N], a_pv[N];
  logic [N-1:0] m_acc, m_flags;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      while (q.size() > 0 && q[0].due <= cyc) begin
        me = q.pop_front();
        total++;
        if (me.due != cyc || {enable, spr_id, R, G, B} !== {me.en, 2'(me.id), me.rgb}) begin
          bad++;
          $display("FAIL pix due=%0d cyc=%0d got en=%0b id=%0d rgb=%h exp en=%0b id=%0d rgb=%h",
                   me.due, cyc, enable, spr_id, {R, G, B}, me.en, me.id, me.rgb);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic model_pix(input int x, input int y, output bit en, output int id,
                           output logic [23:0] rgb, output logic [N-1:0] opq);
    logic [23:0] c;
    en = 0; id = 0; rgb = '0; opq = '0;
    for (int s = N - 1; s >= 0; s--) begin
      if (a_pv[s] && x >= a_px[s] && x < a_px[s] + SW && y >= a_py[s] && y < a_py[s] + SH) begin
        c = rom_fn(s, x - a_px[s], y - a_py[s]);
        if (c != KEY) begin
          opq[s] = 1'b1; en = 1; id = s; rgb = c;
        end
      end
    end
  endtask

  task automatic step(input int x, input int y, input bit wr, input int idx,
                      input int px, input int py, input bit vis, input bit fs);
    bit en; int id; logic [23:0] rgb; logic [N-1:0] opq; exp_t e; cl_t c;
    model_pix(x, y, en, id, rgb, opq);
    e.due = cyc + LAT + 2; e.en = en; e.id = id; e.rgb = rgb;
    q.push_back(e);
    while (cq.size() > 0 && cq[0].t < cyc) begin
      m_acc |= cq[0].b;
      void'(cq.pop_front());
    end
    if (fs) begin
      m_flags = m_acc;
      m_acc = '0;
      while (cq.size() > 0 && cq[0].t == cyc) begin
        m_acc |= cq[0].b;
        void'(cq.pop_front());
      end
    end
    if ($countones(opq) >= 2) begin
      c.t = cyc + LAT + 1; c.b = opq;
      cq.push_back(c);
    end
    if (wr && idx < N) begin
      m_px[idx] = px; m_py[idx] = py; m_pv[idx] = vis;
    end
    if (fs) begin
      a_px = m_px; a_py = m_py; a_pv = m_pv;
    end
    vga_x = CW'(x); vga_y = CW'(y);
    pos_wr = wr; pos_idx = 2'(idx); pos_x = CW'(px); pos_y = CW'(py);
    pos_vis = vis; frame_start = fs;
    @(posedge clk); #1;
  endtask

  task automatic pix(input int x, input int y);
    step(x, y, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wr_pos(input int idx, input int px, input int py, input bit vis, input bit fs);
    step(1023, 1023, 1, idx, px, py, vis, fs);
  endtask

  task automatic drain();
    for (int k = 0; k < LAT + 3; k++) pix(1023, 1023);
  endtask

  task automatic chk_fs();
`ifdef SPRITE_COLLISION_EN
    chk("coll_valid", 32'(coll_valid), 32'd1);
    chk("coll_flags", 32'(coll_flags), 32'(m_flags));
`else
    chk("coll_valid", 32'(coll_valid), 32'd0);
    chk("coll_flags", 32'(coll_flags), 32'd0);
`endif
  endtask

  task automatic model_reset();
    q.delete(); cq.delete();
    m_acc = '0; m_flags = '0;
    for (int s = 0; s < N; s++) begin
      m_px[s] = 0; m_py[s] = 0; m_pv[s] = 0;
      a_px[s] = 0; a_py[s] = 0; a_pv[s] = 0;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rst = 1'b1;
    vga_x = '0; vga_y = '0; pos_x = '0; pos_y = '0;
    pos_wr = 0; pos_idx = '0; pos_vis = 0; frame_start = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_en", 32'(enable), 0);
    chk("rst_rgb", 32'({R, G, B}), 0);
    chk("rst_id", 32'(spr_id), 0);
    chk("rst_cf", 32'(coll_flags), 0);
    chk("rst_cv", 32'(coll_valid), 0);
    chk("rst_romx", 32'(rom_x), 0);
    rst = 1'b0;

    // Single sprite placement and edges.
    wr_pos(0, 100, 50, 1, 1);
    pix(100, 50);
    chk("romx_0", 32'(rom_x[4:0]), 0);
    chk("romy_0", 32'(rom_y[4:0]), 0);
    pix(132, 50);
    pix(131, 81);
    chk("romx_31", 32'(rom_x[4:0]), 31);
    chk("romy_31", 32'(rom_y[4:0]), 31);
    pix(99, 50);
    pix(100, 82);
    drain();

    // Overlap priority and transparency fall-through.
    wr_pos(1, 110, 50, 1, 1);
    pix(115, 55);
    pix(135, 55);
    drain();
    key_all[0] = 1'b1;
    pix(115, 55);
    pix(105, 55);
    drain();
    key_all[0] = 1'b0;

    // Right-edge behaviour, including a position whose end would wrap.
    wr_pos(2, 630, 0, 1, 0);
    wr_pos(3, 1010, 0, 1, 1);
    pix(5, 0);
    pix(639, 0);
    chk("romx_9", 32'(rom_x[14:10]), 9);
    pix(1023, 0);
    chk("romx_13", 32'(rom_x[19:15]), 13);
    pix(2, 3);

    // Pending writes stay hidden until frame_start; same-cycle write is bypassed.
    wr_pos(2, 200, 200, 1, 0);
    pix(639, 0);
    pix(210, 210);
    step(1023, 1023, 1, 2, 300, 300, 1, 1);
    chk_fs();
    pix(310, 310);
    chk("cv_drop", 32'(coll_valid), 0);
    pix(210, 210);
    pix(639, 0);
    drain();

    // Collision between sprites 1 and 3 over four columns.
    wr_pos(0, 0, 0, 0, 0);
    wr_pos(2, 0, 0, 0, 0);
    wr_pos(1, 50, 100, 1, 0);
    wr_pos(3, 78, 100, 1, 1);
    for (int x = 70; x < 90; x++) pix(x, 100);
    drain();
    step(1023, 1023, 0, 0, 0, 0, 0, 1);
    chk_fs();
`ifdef SPRITE_COLLISION_EN
    chk("coll_1010", 32'(coll_flags), 32'b1010);
`endif
    pix(60, 110);
    chk("cv_drop2", 32'(coll_valid), 0);
    drain();
    step(1023, 1023, 0, 0, 0, 0, 0, 1);
    chk_fs();
    drain();

    // Randomised traffic around active sprites.
    pat_en = 1'b1;
    for (int s = 0; s < N; s++)
      wr_pos(s, $urandom_range(0, 120), $urandom_range(0, 120), 1, s == N - 1);
    for (int n = 0; n < 400; n++) begin
      int s, x, y;
      bit wr, fs;
      wr = $urandom_range(0, 99) < 6;
      fs = $urandom_range(0, 49) == 0;
      s = $urandom_range(0, N - 1);
      x = (a_px[s] + int'($urandom_range(0, 40)) - 4) & 1023;
      y = (a_py[s] + int'($urandom_range(0, 40)) - 4) & 1023;
      step(x, y, wr, $urandom_range(0, N - 1), $urandom_range(0, 1023),
           $urandom_range(0, 1023), $urandom_range(0, 3) != 0, fs);
      if (fs) chk_fs();
    end

    // Mid-line reset clears output and all visibility.
    wr_pos(0, 100, 50, 1, 1);
    pix(101, 51);
    pix(102, 51);
    q.delete();
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_en", 32'(enable), 0);
    chk("mid_rst_rgb", 32'({R, G, B}), 0);
    @(posedge clk); #1;
    model_reset();
    rst = 1'b0;
    pix(101, 51);
    pix(0, 0);
    wr_pos(0, 100, 50, 1, 0);
    pix(101, 51);
    step(1023, 1023, 0, 0, 0, 0, 0, 1);
    pix(101, 51);
    pix(103, 60);
    drain();

    w = 0;
    while (q.size() > 0 && w < 20) begin
      @(posedge clk);
      w++;
    end
    #1;
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL sb_drain got=%0d left exp=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
